frame_scheduler: RTL

- Per-frame sequencer between the sprite draw queue, the sprite drawer and the framebuffer master.
- On each vsync assertion it requests a buffer swap, clears the new back buffer, then drains the sprite queue into the drawer one command at a time.
- When the drawer is idle it signals frame completion.
- Owns the `fb_resetting` indication and the clear write port.

---
 rtl/frame_scheduler.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/frame_scheduler.sv
// Per-frame sequencer: on each vsync start edge it swaps buffers, clears the new back buffer,
// then feeds queued sprite commands to the drawer one at a time.
module frame_scheduler #(
    parameter int unsigned FB_PIXELS        = 307200,
    parameter int unsigned ADDR_W           = 19,
    parameter logic [3:0]  CLEAR_COLOR      = 4'h0,
    parameter int unsigned MAX_SPRITES      = 255,
    parameter bit          VSYNC_ACTIVE_LOW = 1'b1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              vsync,
    output logic              swap_req,
    input  logic              swap_ack,
    output logic              fb_resetting,
    output logic [ADDR_W-1:0] clr_addr,
    output logic [3:0]        clr_data,
    output logic              clr_en,
    output logic              dequeue,
    input  logic              is_empty,
    input  logic [7:0]        q_id,
    input  logic [15:0]       q_x,
    input  logic [15:0]       q_y,
    input  logic [7:0]        q_scale,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic [7:0]        cmd_id,
    output logic [15:0]       cmd_x,
    output logic [15:0]       cmd_y,
    output logic [7:0]        cmd_scale,
    input  logic              draw_busy,
    output logic              frame_done,
    output logic              overrun,
    output logic [7:0]        sprite_count
);

    localparam logic              VsyncIdle = VSYNC_ACTIVE_LOW ? 1'b1 : 1'b0;
    localparam logic [ADDR_W-1:0] LastAddr  = ADDR_W'(FB_PIXELS - 1);
    localparam logic [7:0]        MaxCount  = 8'(MAX_SPRITES);

    typedef enum logic [2:0] {
        StWaitVsync,
        StSwap,
        StClear,
        StFetch,
        StLoad,
        StIssue,
        StDrain
    } state_e;

    state_e            state_q, state_d;
    logic              vsync_q;
    logic              swap_req_q, swap_req_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              clr_en_q, clr_en_d;
    logic              fb_res_q, fb_res_d;
    logic [3:0]        clr_data_q, clr_data_d;
    logic              cmd_valid_q, cmd_valid_d;
    logic [7:0]        cmd_id_q, cmd_id_d;
    logic [15:0]       cmd_x_q, cmd_x_d;
    logic [15:0]       cmd_y_q, cmd_y_d;
    logic [7:0]        cmd_scale_q, cmd_scale_d;
    logic              frame_done_q, frame_done_d;
    logic              overrun_q, overrun_d;
    logic [7:0]        sprite_count_q, sprite_count_d;

    logic start_edge;
    logic fetch_go;

    assign start_edge = (vsync != VsyncIdle) && (vsync_q == VsyncIdle);
    // Pop is decided combinationally in FETCH so the head is valid during LOAD.
    assign fetch_go   = (state_q == StFetch) && !is_empty && (sprite_count_q != MaxCount);

    always_comb begin
        state_d        = state_q;
        swap_req_d     = swap_req_q;
        addr_d         = addr_q;
        clr_en_d       = 1'b0;
        fb_res_d       = 1'b0;
        clr_data_d     = 4'h0;
        cmd_valid_d    = cmd_valid_q;
        cmd_id_d       = cmd_id_q;
        cmd_x_d        = cmd_x_q;
        cmd_y_d        = cmd_y_q;
        cmd_scale_d    = cmd_scale_q;
        frame_done_d   = 1'b0;
        overrun_d      = start_edge && (state_q != StWaitVsync);
        sprite_count_d = sprite_count_q;

        case (state_q)
            StWaitVsync: begin
                if (start_edge) begin
                    swap_req_d = 1'b1;
                    state_d    = StSwap;
                end
            end
            StSwap: begin
                if (swap_ack) begin
                    swap_req_d     = 1'b0;
                    addr_d         = '0;
                    sprite_count_d = 8'h00;
                    clr_en_d       = 1'b1;
                    fb_res_d       = 1'b1;
                    clr_data_d     = CLEAR_COLOR;
                    state_d        = StClear;
                end
            end
            StClear: begin
                // clr_en_q already covers the current address; stop after the last one.
                if (addr_q == LastAddr) begin
                    addr_d  = '0;
                    state_d = StFetch;
                end else begin
                    addr_d     = addr_q + ADDR_W'(1);
                    clr_en_d   = 1'b1;
                    fb_res_d   = 1'b1;
                    clr_data_d = CLEAR_COLOR;
                end
            end
            StFetch: begin
                state_d = fetch_go ? StLoad : StDrain;
            end
            StLoad: begin
                cmd_id_d    = q_id;
                cmd_x_d     = q_x;
                cmd_y_d     = q_y;
                cmd_scale_d = q_scale;
                cmd_valid_d = 1'b1;
                state_d     = StIssue;
            end
            StIssue: begin
                if (cmd_ready) begin
                    cmd_valid_d = 1'b0;
                    if (sprite_count_q != MaxCount) begin
                        sprite_count_d = sprite_count_q + 8'd1;
                    end
                    state_d = StFetch;
                end
            end
            StDrain: begin
                if (!draw_busy) begin
                    frame_done_d = 1'b1;
                    state_d      = StWaitVsync;
                end
            end
            default: state_d = StWaitVsync;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q        <= StWaitVsync;
            vsync_q        <= VsyncIdle;
            swap_req_q     <= 1'b0;
            addr_q         <= '0;
            clr_en_q       <= 1'b0;
            fb_res_q       <= 1'b0;
            clr_data_q     <= 4'h0;
            cmd_valid_q    <= 1'b0;
            cmd_id_q       <= 8'h00;
            cmd_x_q        <= 16'h0000;
            cmd_y_q        <= 16'h0000;
            cmd_scale_q    <= 8'h00;
            frame_done_q   <= 1'b0;
            overrun_q      <= 1'b0;
            sprite_count_q <= 8'h00;
        end else begin
            state_q        <= state_d;
            vsync_q        <= vsync;
            swap_req_q     <= swap_req_d;
            addr_q         <= addr_d;
            clr_en_q       <= clr_en_d;
            fb_res_q       <= fb_res_d;
            clr_data_q     <= clr_data_d;
            cmd_valid_q    <= cmd_valid_d;
            cmd_id_q       <= cmd_id_d;
            cmd_x_q        <= cmd_x_d;
            cmd_y_q        <= cmd_y_d;
            cmd_scale_q    <= cmd_scale_d;
            frame_done_q   <= frame_done_d;
            overrun_q      <= overrun_d;
            sprite_count_q <= sprite_count_d;
        end
    end

    assign swap_req     = swap_req_q;
    assign fb_resetting = fb_res_q;
    assign clr_addr     = addr_q;
    assign clr_data     = clr_data_q;
    assign clr_en       = clr_en_q;
    assign dequeue      = fetch_go;
    assign cmd_valid    = cmd_valid_q;
    assign cmd_id       = cmd_id_q;
    assign cmd_x        = cmd_x_q;
    assign cmd_y        = cmd_y_q;
    assign cmd_scale    = cmd_scale_q;
    assign frame_done   = frame_done_q;
    assign overrun      = overrun_q;
    assign sprite_count = sprite_count_q;

endmodule
